// File: rtl/eth_frame_transmission_if.sv
// Frame request fields and PHY byte stream of the Ethernet frame transmitter.
// The master side issues requests; the transmitter is the slave.
interface eth_frame_transmission_if;
    logic        start;
    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic [31:0] data_in;
    logic [7:0]  tx_out;
    logic        tx_en;
    logic        tx_done;
    logic [3:0]  state;
    logic [3:0]  next_state;
    logic        crc_done;
    logic [2:0]  byte_count;
    logic [31:0] crc__out;

    modport master (
        output start,
        output dest_addr,
        output src_addr,
        output eth_type,
        output data_in,
        input  tx_out,
        input  tx_en,
        input  tx_done,
        input  state,
        input  next_state,
        input  crc_done,
        input  byte_count,
        input  crc__out
    );

    modport slave (
        input  start,
        input  dest_addr,
        input  src_addr,
        input  eth_type,
        input  data_in,
        output tx_out,
        output tx_en,
        output tx_done,
        output state,
        output next_state,
        output crc_done,
        output byte_count,
        output crc__out
    );
endinterface

// File: rtl/eth_frame_transmission.sv
// Byte-serial Ethernet transmitter: preamble, SFD, header, 4-byte payload
// and reflected CRC-32 FCS, one byte per clock.
module eth_frame_transmission (
    input logic                    clk,
    input logic                    rst_n,
    eth_frame_transmission_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_SFD      = 4'd2,
        S_DEST     = 4'd3,
        S_SRC      = 4'd4,
        S_TYPE     = 4'd5,
        S_PAYLOAD  = 4'd6,
        S_CRC      = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       cnt_q;
    logic [5:0][7:0]  dest_q;
    logic [5:0][7:0]  src_q;
    logic [1:0][7:0]  type_q;
    logic [3:0][7:0]  data_q;
    logic [31:0]      crc_q;
    logic             crc_done_q;
    logic [3:0][7:0]  fcs;
    logic [7:0]       tx_byte;
    logic [3:0]       st;
    logic             crc_en;
    logic             accept;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs    = ~crc_q;
    assign st     = state_q;
    assign accept = (state_q == S_IDLE) && bus.start;
    assign crc_en = (state_q == S_DEST) || (state_q == S_SRC) ||
                    (state_q == S_TYPE) || (state_q == S_PAYLOAD);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (bus.start)      state_d = S_PREAMBLE;
            S_PREAMBLE: if (cnt_q == 3'd6)  state_d = S_SFD;
            S_SFD:                          state_d = S_DEST;
            S_DEST:     if (cnt_q == 3'd5)  state_d = S_SRC;
            S_SRC:      if (cnt_q == 3'd5)  state_d = S_TYPE;
            S_TYPE:     if (cnt_q == 3'd1)  state_d = S_PAYLOAD;
            S_PAYLOAD:  if (cnt_q == 3'd3)  state_d = S_CRC;
            S_CRC:      if (cnt_q == 3'd3)  state_d = S_DONE;
            S_DONE:                         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // MSB byte of each field goes first; FCS goes out LSB byte first
    always_comb begin
        tx_byte = 8'h00;
        unique case (state_q)
            S_PREAMBLE: tx_byte = 8'h55;
            S_SFD:      tx_byte = 8'hD5;
            S_DEST:     tx_byte = dest_q[3'd5 - cnt_q];
            S_SRC:      tx_byte = src_q[3'd5 - cnt_q];
            S_TYPE:     tx_byte = type_q[~cnt_q[0]];
            S_PAYLOAD:  tx_byte = data_q[~cnt_q[1:0]];
            S_CRC:      tx_byte = fcs[cnt_q[1:0]];
            default:    tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            dest_q     <= '0;
            src_q      <= '0;
            type_q     <= '0;
            data_q     <= '0;
            crc_q      <= 32'hFFFFFFFF;
            crc_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || (state_q == S_IDLE)) begin
                cnt_q <= 3'd0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (accept) begin
                dest_q <= bus.dest_addr;
                src_q  <= bus.src_addr;
                type_q <= bus.eth_type;
                data_q <= bus.data_in;
                crc_q  <= 32'hFFFFFFFF;
            end else if (crc_en) begin
                crc_q <= crc_byte(crc_q, tx_byte);
            end
            if (accept || (state_d == S_IDLE)) begin
                crc_done_q <= 1'b0;
            end else if ((state_q == S_PAYLOAD) && (state_d == S_CRC)) begin
                crc_done_q <= 1'b1;
            end
        end
    end

    assign bus.tx_out     = tx_byte;
    assign bus.tx_en      = (st != 4'd0) && (st <= 4'd7);
    assign bus.tx_done    = (state_q == S_DONE);
    assign bus.state      = st;
    assign bus.next_state = state_d;
    assign bus.crc_done   = crc_done_q;
    assign bus.byte_count = cnt_q;
    assign bus.crc__out   = fcs;

endmodule

// File: tb/tb_eth_frame_transmission.sv
// Self-checking bench for eth_frame_transmission: table of frames driven
// through a byte scoreboard, plus reset and back-to-back sequences.
module tb_eth_frame_transmission;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    eth_frame_transmission_if ifc ();

    eth_frame_transmission dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] et;
        logic [31:0] data;
        int          mode;
        int          exp_len;
    } rec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] crc_tab[256];
    rec_t        tbl[5];
    logic [3:0]  prev_ns;
    bit          ns_valid = 0;
    bit          skip = 0;
    bit          mon_on = 0;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, ifc.state, 4'd0);
        chk({tag, "_next_state"}, ifc.next_state, 4'd0);
        chk({tag, "_byte_count"}, ifc.byte_count, 3'd0);
        chk({tag, "_tx_out"}, ifc.tx_out, 8'h00);
        chk({tag, "_tx_en"}, ifc.tx_en, 1'b0);
        chk({tag, "_tx_done"}, ifc.tx_done, 1'b0);
        chk({tag, "_crc_done"}, ifc.crc_done, 1'b0);
        chk({tag, "_crc_out"}, ifc.crc__out, 32'h0);
    endtask

    // table-driven reference CRC-32, LSB-first
    task automatic push_frame(input rec_t r, output logic [31:0] fcs);
        logic [7:0]  hb[18];
        logic [31:0] c;
        for (int i = 0; i < 6; i++) hb[i] = r.dest[47 - 8*i -: 8];
        for (int i = 0; i < 6; i++) hb[6 + i] = r.src[47 - 8*i -: 8];
        for (int i = 0; i < 2; i++) hb[12 + i] = r.et[15 - 8*i -: 8];
        for (int i = 0; i < 4; i++) hb[14 + i] = r.data[31 - 8*i -: 8];
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 18; i++) begin
            c = crc_tab[c[7:0] ^ hb[i]] ^ (c >> 8);
        end
        fcs = ~c;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 18; i++) exp_q.push_back(hb[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    always @(negedge rst_n) skip = 1;

    always @(negedge clk) begin
        if (mon_on) begin
            if (ns_valid && !skip) chk("next_state", ifc.state, prev_ns);
            if (rst_n && ifc.tx_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h expected none",
                             ifc.tx_out);
                end else begin
                    chk("tx_out", ifc.tx_out, exp_q.pop_front());
                end
            end
        end
        skip = 0;
        prev_ns = ifc.next_state;
        ns_valid = rst_n;
    end

    task automatic set_inputs(input rec_t r);
        ifc.dest_addr = r.dest;
        ifc.src_addr  = r.src;
        ifc.eth_type  = r.et;
        ifc.data_in   = r.data;
    endtask

    // runs from just after the accept edge until the DONE cycle
    task automatic wait_frame(input int mode, input logic [31:0] fcs,
                              input int exp_len);
        int en_cnt = 0;
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ifc.tx_en) en_cnt++;
            if (mode == 1 && ifc.state == 4'd3 && ifc.byte_count == 3'd2) begin
                ifc.dest_addr = ~ifc.dest_addr;
                ifc.src_addr  = 48'h0;
                ifc.eth_type  = 16'h86DD;
                ifc.data_in   = 32'h55AA55AA;
            end
            if (mode == 2 && ifc.state == 4'd4 && ifc.byte_count == 3'd1)
                ifc.start = 1'b1;
            if (mode == 2 && ifc.state == 4'd4 && ifc.byte_count == 3'd2)
                ifc.start = 1'b0;
            if (ifc.state == 4'd6 && ifc.byte_count == 3'd3)
                chk("crc_done_pre", ifc.crc_done, 1'b0);
            if (ifc.state == 4'd7 && ifc.byte_count == 3'd0) begin
                chk("crc_done_entry", ifc.crc_done, 1'b1);
                chk("fcs_entry", ifc.crc__out, fcs);
            end
            if (ifc.state == 4'd8) begin
                chk("tx_done", ifc.tx_done, 1'b1);
                chk("done_tx_out", ifc.tx_out, 8'h00);
                chk("done_tx_en", ifc.tx_en, 1'b0);
                chk("fcs_done", ifc.crc__out, fcs);
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no DONE expected DONE");
        end
        chk("tx_en_cycles", en_cnt, exp_len);
    endtask

    task automatic run_frame(input rec_t r);
        logic [31:0] fcs;
        push_frame(r, fcs);
        @(posedge clk); #1;
        set_inputs(r);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        wait_frame(r.mode, fcs, r.exp_len);
        @(negedge clk);
        chk("idle_state", ifc.state, 4'd0);
        chk("idle_tx_done", ifc.tx_done, 1'b0);
        chk("idle_crc_done", ifc.crc_done, 1'b0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fcs;
        bit          hit;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = i;
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        tbl[0] = '{48'h123456789ABC, 48'hABCDEF123456, 16'h0800,
                   32'h11223344, 0, 30};
        tbl[1] = '{48'h123456789ABC, 48'hABCDEF123456, 16'h0800,
                   32'h11223344, 1, 30};
        tbl[2] = '{48'h0, 48'h0, 16'h0, 32'h0, 0, 30};
        tbl[3] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 16'hFFFF,
                   32'hFFFFFFFF, 0, 30};
        tbl[4] = '{48'h0180C2000001, 48'h001122334455, 16'h8808,
                   32'hDEADBEEF, 2, 30};

        ifc.start = 1'b0;
        set_inputs(tbl[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        #2 rst_n = 1'b1;
        mon_on = 1;

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);

        push_frame(tbl[0], fcs);
        @(posedge clk); #1;
        set_inputs(tbl[0]);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (ifc.state == 4'd6) hit = 1;
        end
        chk("reach_payload", hit, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("midreset_hold");
        #2 rst_n = 1'b1;
        run_frame(tbl[0]);

        push_frame(tbl[3], fcs);
        push_frame(tbl[3], fcs);
        @(posedge clk); #1;
        set_inputs(tbl[3]);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        wait_frame(0, fcs, 30);
        @(negedge clk);
        chk("b2b_idle", ifc.state, 4'd0);
        chk("b2b_next", ifc.next_state, 4'd1);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        wait_frame(0, fcs, 30);
        @(negedge clk);
        chk("b2b_end_state", ifc.state, 4'd0);
        chk("b2b_sb_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_frame_transmission.md
# eth_frame_transmission

Byte-serial Ethernet frame transmitter. On a `start` pulse it latches destination address, source address, EtherType and a 4-byte payload, then emits one byte per clock: preamble, SFD, header, payload and FCS (IEEE 802.3 CRC-32). It sits between the MAC control logic and the byte-wide PHY transmit interface. It exposes FSM and CRC status for debug and verification.

## Interface
- Parameters: none.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a frame; sampled only in IDLE.
- `dest_addr` input 48: destination MAC; bits [47:40] are sent first.
- `src_addr` input 48: source MAC; bits [47:40] are sent first.
- `eth_type` input 16: EtherType; bits [15:8] are sent first.
- `data_in` input 32: payload; bits [31:24] are sent first.
- `tx_out` output 8: transmit byte.
- `tx_en` output 1: `tx_out` valid (PREAMBLE through CRC).
- `tx_done` output 1: one-cycle end-of-frame pulse.
- `state` output 4: current FSM state.
- `next_state` output 4: combinational next FSM state.
- `crc_done` output 1: FCS computation complete for the current frame.
- `byte_count` output 3: byte index within the current field.
- `crc__out` output 32: current FCS value, equal to the bitwise complement of the CRC register.

## Operation
- State encodings:
  - IDLE=0
  - PREAMBLE=1
  - SFD=2
  - DEST=3
  - SRC=4
  - TYPE=5
  - PAYLOAD=6
  - CRC=7
  - DONE=8
  - 9–15 are illegal and go to IDLE.
- Field lengths (`byte_count` runs 0..N-1, then the FSM advances and `byte_count` clears to 0):
  - PREAMBLE: 7 bytes, 0x55.
  - SFD: 1 byte, 0xD5.
  - DEST: 6 bytes.
  - SRC: 6 bytes.
  - TYPE: 2 bytes.
  - PAYLOAD: 4 bytes.
  - CRC: 4 bytes.
  - DONE: 1 cycle, then IDLE.
- Byte `k` of a multi-byte field is `field[W-1-8k -: 8]` (MSB byte first).
- CRC bytes, in order: `crc__out[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- `tx_out`, `tx_en`, `tx_done` are combinational decodes of `state` and `byte_count`.
  - `tx_en`=1 in states 1–7.
  - `tx_done`=1 only in DONE.
  - `tx_out`=0x00 in IDLE and DONE.
- Accepting a frame (IDLE with `start`=1 at a clock edge): latch all four input fields into internal registers, set the CRC register to 0xFFFFFFFF, clear `crc_done`, go to PREAMBLE. Later input changes do not affect the frame in flight.
- `start` is ignored outside IDLE. A held `start` re-triggers a new frame from IDLE after DONE.
- CRC algorithm: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, one byte per clock.
  - Updated at each edge in DEST, SRC, TYPE and PAYLOAD using the current `tx_out` byte (18 bytes total).
  - Not updated in any other state.
- `crc_done` is set at the edge leaving PAYLOAD and held until the FSM enters IDLE.

## Timing
- Reset (asynchronous, any time including mid-frame): the FSM returns to IDLE and all registers clear.
  - Outputs while `rst_n`=0 (with `start`=0): `state`=0, `next_state`=0, `byte_count`=0, `tx_out`=0x00, `tx_en`=0, `tx_done`=0, `crc_done`=0, CRC register=0xFFFFFFFF, so `crc__out`=0x00000000.
- Latency: the edge sampling `start` puts PREAMBLE byte 0 on `tx_out` in the following cycle.
- Frame length: 30 cycles with `tx_en`=1 (8 preamble/SFD + 18 header/payload + 4 FCS), then 1 DONE cycle, then IDLE. Total 31 cycles from the accept edge to re-entering IDLE.
- `crc__out` is stable and final from the first CRC cycle through DONE.
- `next_state` always equals the state that the next edge will load (absent reset).

## Test plan
- Reset check: hold `rst_n`=0 and toggle `clk` -> every output at its reset value; `crc__out`=0x00000000.
- Basic frame: `dest_addr`=0x123456789ABC, `src_addr`=0xABCDEF123456, `eth_type`=0x0800, `data_in`=0x11223344, one-cycle `start` -> exactly this sequence on `tx_out`, with `tx_en`=1 for 30 cycles:
  - 55×7, D5
  - 12 34 56 78 9A BC
  - AB CD EF 12 34 56
  - 08 00
  - 11 22 33 44
  - 4 FCS bytes
- FCS check on the basic frame -> `crc__out` equals an independent reference-model CRC-32 of those 18 bytes. `crc_done` rises at CRC entry. The FCS bytes appear LSB first. `tx_done` pulses one cycle, then `state`=0.
- Input change mid-frame: alter all inputs during DEST -> transmitted bytes and FCS identical to the basic frame.
- Reset mid-frame: assert `rst_n`=0 during PAYLOAD -> immediate IDLE with all outputs at reset values. Next `start` produces a complete, correct frame.
- Start during busy and back-to-back: pulse `start` in SRC -> ignored. Hold `start`=1 through DONE -> a second frame begins in the cycle after IDLE with a fresh CRC.
